instr_encoder: RTL

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// Purpose: packs RV32 R/I/LOAD/STORE/BRANCH field bundles into 32-bit words tagged with a word address.
// Latency: one cycle from bundle acceptance to out_valid; sustains one word per cycle.
// Backpressure: single output register, in_ready = !out_valid || out_ready; illegal bundles are dropped and counted.
module instr_encoder #(
    parameter int INSTRSIZE = 32,
    parameter int IMMSIZE   = 32,
    parameter int ADDRW     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           fmt,
    input  logic [4:0]           rd,
    input  logic [4:0]           rs1,
    input  logic [4:0]           rs2,
    input  logic [2:0]           funct3,
    input  logic [6:0]           funct7,
    input  logic [IMMSIZE-1:0]   imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [INSTRSIZE-1:0] instruction,
    output logic [ADDRW-1:0]     out_addr,
    output logic                 imm_err,
    output logic [7:0]           err_cnt
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 accept;
    logic                 out_hs;
    logic                 legal;
    logic                 load;
    logic [31:0]          enc;
    logic [ADDRW-1:0]     addr_cnt;
    logic [ADDRW-1:0]     addr_inc;
    logic signed [IMMSIZE-1:0] simm;
    logic                 imm12_ok;
    logic                 imm13_ok;

    assign simm      = imm;
    assign in_ready  = (state == EMPTY) || out_ready;
    assign out_valid = (state == FULL);
    assign accept    = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;
    assign addr_inc  = addr_cnt + ADDRW'(1);

    // 12-bit signed range for I/LOAD/STORE; 13-bit even range for BRANCH offsets.
    assign imm12_ok = (simm >= -2048) && (simm <= 2047);
    assign imm13_ok = (simm >= -4096) && (simm <= 4094) && !imm[0];

    // Field packing and legality for the current bundle.
    always_comb begin
        enc   = '0;
        legal = 1'b0;
        case (fmt)
            3'd0: begin
                enc   = {funct7, rs2, rs1, funct3, rd, 7'b0110011};
                legal = 1'b1;
            end
            3'd1: begin
                enc   = {imm[11:0], rs1, funct3, rd, 7'b0010011};
                legal = imm12_ok;
            end
            3'd2: begin
                enc   = {imm[11:0], rs1, funct3, rd, 7'b0000011};
                legal = imm12_ok;
            end
            3'd3: begin
                enc   = {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011};
                legal = imm12_ok;
            end
            3'd4: begin
                enc   = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'b1100011};
                legal = imm13_ok;
            end
            default: begin
                enc   = '0;
                legal = 1'b0;
            end
        endcase
    end

    // Output register occupancy: a legal accept refills, otherwise a handshake drains.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        if (accept && legal) begin
            load      = 1'b1;
            state_nxt = FULL;
        end else if (out_hs) begin
            state_nxt = EMPTY;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Output word and its address; a same-edge handshake means the new word gets the next address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instruction <= '0;
            out_addr    <= '0;
        end else if (load) begin
            instruction <= INSTRSIZE'(enc);
            out_addr    <= out_hs ? addr_inc : addr_cnt;
        end
    end

    // Address counter advances once per consumed word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_cnt <= '0;
        end else if (out_hs) begin
            addr_cnt <= addr_inc;
        end
    end

    // Sticky error flag and saturating reject counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            imm_err <= 1'b0;
            err_cnt <= '0;
        end else if (accept && !legal) begin
            imm_err <= 1'b1;
            if (err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule
